// File: rtl/moldudp64_tx_if.sv
// Bundle of the packet-request, message-beat and AXI-stream signals of the MoldUDP64 packet builder.
// The slave modport is the builder's view and the master modport is the source/sink view.
interface moldudp64_tx_if #(
    parameter int AXI_DATA_W = 64,
    parameter int AXI_KEEP_W = AXI_DATA_W / 8,
    parameter int SID_W      = 80,
    parameter int SEQ_W      = 64,
    parameter int ML_W       = 16
);
    logic                  seq_load_i;
    logic [SEQ_W-1:0]      seq_i;
    logic                  pkt_v_i;
    logic                  pkt_ready_o;
    logic [SID_W-1:0]      pkt_sid_i;
    logic [ML_W-1:0]       pkt_msg_cnt_i;
    logic                  mold_msg_v_i;
    logic                  mold_msg_ready_o;
    logic                  mold_msg_start_i;
    logic [ML_W-1:0]       mold_msg_len_i;
    logic [AXI_KEEP_W-1:0] mold_msg_mask_i;
    logic [AXI_DATA_W-1:0] mold_msg_data_i;
    logic                  upd_axis_tvalid_o;
    logic [AXI_KEEP_W-1:0] upd_axis_tkeep_o;
    logic [AXI_DATA_W-1:0] upd_axis_tdata_o;
    logic                  upd_axis_tlast_o;
    logic                  upd_axis_tuser_o;
    logic                  upd_axis_tready_i;

    modport slave (
        input  seq_load_i, seq_i, pkt_v_i, pkt_sid_i, pkt_msg_cnt_i,
        input  mold_msg_v_i, mold_msg_start_i, mold_msg_len_i, mold_msg_mask_i, mold_msg_data_i,
        input  upd_axis_tready_i,
        output pkt_ready_o, mold_msg_ready_o,
        output upd_axis_tvalid_o, upd_axis_tkeep_o, upd_axis_tdata_o, upd_axis_tlast_o, upd_axis_tuser_o
    );

    modport master (
        output seq_load_i, seq_i, pkt_v_i, pkt_sid_i, pkt_msg_cnt_i,
        output mold_msg_v_i, mold_msg_start_i, mold_msg_len_i, mold_msg_mask_i, mold_msg_data_i,
        output upd_axis_tready_i,
        input  pkt_ready_o, mold_msg_ready_o,
        input  upd_axis_tvalid_o, upd_axis_tkeep_o, upd_axis_tdata_o, upd_axis_tlast_o, upd_axis_tuser_o
    );
endinterface

// File: rtl/moldudp64_tx.sv
// MoldUDP64 packet builder: 20-byte header plus length-prefixed messages, byte-packed onto a
// 64-bit AXI-stream through a byte accumulator whose lane 0 always holds the next byte to send.
module moldudp64_tx #(
    parameter int AXI_DATA_W = 64,
    parameter int AXI_KEEP_W = AXI_DATA_W / 8,
    parameter int SID_W      = 80,
    parameter int SEQ_W      = 64,
    parameter int ML_W       = 16
) (
    input logic           clk,
    input logic           nreset,
    moldudp64_tx_if.slave bus
);
    // 17 byte slots: a 7-byte residue (no beat presentable) plus a 10-byte start beat always fit,
    // so message intake can never stall with nothing to send.
    localparam int         ACC_BYTES = 2 * AXI_KEEP_W + 1;
    localparam int         ACC_W     = 8 * ACC_BYTES;
    localparam logic [4:0] BEAT_B    = 5'(AXI_KEEP_W);
    localparam logic [4:0] HDR_ROOM  = 5'(ACC_BYTES - 4);
    localparam logic [4:0] MSG_ROOM  = 5'(ACC_BYTES - AXI_KEEP_W - 2);

    typedef enum logic [1:0] {IDLE, HDR, MSG, FLUSH} state_t;

    state_t           state, state_nxt;
    logic             run_q;
    logic [ACC_W-1:0] acc, acc_nxt, push_d;
    logic [4:0]       lvl, lvl_nxt, push_n, leave, a_rem;
    logic [SEQ_W-1:0] seq_q, seq_nxt;
    logic [31:0]      hdr_tail, hdr_tail_nxt;
    logic [ML_W-1:0]  cnt_q, cnt_nxt, rem_q, rem_nxt;
    logic [ML_W-1:0]  cur_rem, rem_after;
    logic [3:0]       n_data;
    logic [AXI_DATA_W-1:0] beat_data;
    logic             tvalid, tlast, take, msg_ready;

    function automatic logic [AXI_DATA_W-1:0] lane_mask(input logic [3:0] n,
                                                        input logic [AXI_KEEP_W-1:0] m);
        lane_mask = '0;
        for (int i = 0; i < AXI_KEEP_W; i++)
            if (i < int'(n) && m[i]) lane_mask[8*i +: 8] = 8'hFF;
    endfunction

    function automatic logic [AXI_KEEP_W-1:0] keep_of(input logic [4:0] n);
        keep_of = '0;
        for (int i = 0; i < AXI_KEEP_W; i++) keep_of[i] = (i < int'(n));
    endfunction

    assign tvalid    = (lvl >= BEAT_B) || (state == FLUSH && lvl != 5'd0);
    assign tlast     = tvalid && state == FLUSH && lvl <= BEAT_B;
    assign take      = tvalid && bus.upd_axis_tready_i;
    assign leave     = take ? ((lvl >= BEAT_B) ? BEAT_B : lvl) : 5'd0;
    assign a_rem     = lvl - leave;
    assign msg_ready = (state == MSG) && (a_rem <= MSG_ROOM);

    assign bus.upd_axis_tvalid_o = tvalid;
    assign bus.upd_axis_tlast_o  = tlast;
    assign bus.upd_axis_tkeep_o  = tlast ? keep_of(lvl) : (tvalid ? '1 : '0);
    assign bus.upd_axis_tdata_o  = acc[AXI_DATA_W-1:0];
    assign bus.upd_axis_tuser_o  = 1'b0;
    assign bus.pkt_ready_o       = (state == IDLE) && run_q;
    assign bus.mold_msg_ready_o  = msg_ready;

    // Bytes of the current message beat, taken from the remaining length rather than the mask.
    assign cur_rem   = bus.mold_msg_start_i ? bus.mold_msg_len_i : rem_q;
    assign n_data    = (cur_rem >= ML_W'(AXI_KEEP_W)) ? 4'(AXI_KEEP_W) : cur_rem[3:0];
    assign rem_after = cur_rem - ML_W'(n_data);
    assign beat_data = bus.mold_msg_data_i & lane_mask(n_data, bus.mold_msg_mask_i);

    always_comb begin
        state_nxt    = state;
        push_d       = '0;
        push_n       = 5'd0;
        hdr_tail_nxt = hdr_tail;
        cnt_nxt      = cnt_q;
        rem_nxt      = rem_q;
        seq_nxt      = seq_q;
        case (state)
            IDLE: if (bus.pkt_v_i && run_q) begin
                push_d       = ACC_W'({seq_q[SEQ_W-17:0], bus.pkt_sid_i});
                push_n       = 5'd16;
                hdr_tail_nxt = {bus.pkt_msg_cnt_i, seq_q[SEQ_W-1:SEQ_W-16]};
                cnt_nxt      = bus.pkt_msg_cnt_i;
                seq_nxt      = seq_q + SEQ_W'(bus.pkt_msg_cnt_i);
                state_nxt    = HDR;
            end
            HDR: if (a_rem <= HDR_ROOM) begin
                push_d    = ACC_W'(hdr_tail);
                push_n    = 5'd4;
                state_nxt = (cnt_q != '0) ? MSG : FLUSH;
            end
            MSG: if (bus.mold_msg_v_i && msg_ready) begin
                push_d  = bus.mold_msg_start_i ? ACC_W'({beat_data, bus.mold_msg_len_i})
                                               : ACC_W'(beat_data);
                push_n  = 5'(n_data) + (bus.mold_msg_start_i ? 5'd2 : 5'd0);
                rem_nxt = rem_after;
                if (rem_after == '0) begin
                    cnt_nxt = cnt_q - ML_W'(1);
                    if (cnt_q == ML_W'(1)) state_nxt = FLUSH;
                end
            end
            FLUSH: if (take && tlast) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.seq_load_i) seq_nxt = bus.seq_i;
    end

    // Departing bytes shift out of lane 0; new bytes land just above what remains.
    assign acc_nxt = (acc >> {leave, 3'b000}) | (push_d << {a_rem, 3'b000});
    assign lvl_nxt = a_rem + push_n;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state    <= IDLE;
            run_q    <= 1'b0;
            acc      <= '0;
            lvl      <= 5'd0;
            seq_q    <= '0;
            hdr_tail <= '0;
            cnt_q    <= '0;
            rem_q    <= '0;
        end else begin
            state    <= state_nxt;
            run_q    <= 1'b1;
            acc      <= acc_nxt;
            lvl      <= lvl_nxt;
            seq_q    <= seq_nxt;
            hdr_tail <= hdr_tail_nxt;
            cnt_q    <= cnt_nxt;
            rem_q    <= rem_nxt;
        end
    end
endmodule

// File: tb/tb_moldudp64_tx.sv
// Directed bench for moldudp64_tx: a packet table checked beat by beat against a byte-stream model,
// plus hand-written reset, stall and sequence-load sequences.
module tb_moldudp64_tx;
    logic clk = 1'b0;
    logic nreset;
    always #5 clk = ~clk;

    moldudp64_tx_if bus ();
    moldudp64_tx dut (.clk(clk), .nreset(nreset), .bus(bus.slave));

    typedef struct {
        logic [79:0] sid;
        logic [15:0] cnt;
        int          l0, l1, l2, l3;
        bit          ff, stall, load, pre_rst;
        int          exp_beats;
        logic [7:0]  exp_keep;
        logic [63:0] exp_seq;
    } vec_t;

    vec_t        tbl [8];
    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_bytes [$];
    logic [63:0] cap_data [$];
    logic [7:0]  cap_keep [$];
    logic        cap_last [$];
    bit          msg_rdy_seen;
    logic [63:0] exp_seq;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=timeout required=handshake", name);
    endtask

    function automatic int vlen(input vec_t v, input int m);
        case (m)
            0: return v.l0;
            1: return v.l1;
            2: return v.l2;
            default: return v.l3;
        endcase
    endfunction

    function automatic logic [7:0] dbyte(input bit ff, input int m, input int k);
        return ff ? 8'hFF : 8'(m * 40 + k * 3 + 7);
    endfunction

    task automatic build_exp(input vec_t v, input logic [63:0] seq);
        exp_bytes.delete();
        for (int i = 0; i < 10; i++) exp_bytes.push_back(v.sid[8*i +: 8]);
        for (int i = 0; i < 8; i++) exp_bytes.push_back(seq[8*i +: 8]);
        exp_bytes.push_back(v.cnt[7:0]);
        exp_bytes.push_back(v.cnt[15:8]);
        for (int m = 0; m < int'(v.cnt); m++) begin
            exp_bytes.push_back(8'(vlen(v, m)));
            exp_bytes.push_back(8'(vlen(v, m) >> 8));
            for (int k = 0; k < vlen(v, m); k++) exp_bytes.push_back(dbyte(v.ff, m, k));
        end
    endtask

    task automatic drive(input vec_t v);
        int n;
        @(posedge clk); #1;
        bus.pkt_v_i       = 1'b1;
        bus.pkt_sid_i     = v.sid;
        bus.pkt_msg_cnt_i = v.cnt;
        bus.seq_load_i    = v.load;
        bus.seq_i         = 64'h100;
        n = 0;
        @(negedge clk);
        while (!bus.pkt_ready_o && n < 400) begin @(negedge clk); n++; end
        if (n >= 400) fail_now("pkt_handshake");
        @(posedge clk); #1;
        bus.pkt_v_i    = 1'b0;
        bus.seq_load_i = 1'b0;
        check("first_beat_valid", 128'(bus.upd_axis_tvalid_o), 128'(1));
        check("first_beat_data", 128'(bus.upd_axis_tdata_o), 128'(v.sid[63:0]));
        for (int m = 0; m < int'(v.cnt); m++) begin
            for (int k = 0; k < vlen(v, m); k += 8) begin
                bus.mold_msg_v_i     = 1'b1;
                bus.mold_msg_start_i = (k == 0);
                bus.mold_msg_len_i   = 16'(vlen(v, m));
                for (int j = 0; j < 8; j++) begin
                    bus.mold_msg_mask_i[j]       = (k + j < vlen(v, m));
                    bus.mold_msg_data_i[8*j +: 8] = (k + j < vlen(v, m)) ? dbyte(v.ff, m, k + j) : 8'hAA;
                end
                n = 0;
                @(negedge clk);
                while (!bus.mold_msg_ready_o && n < 400) begin @(negedge clk); n++; end
                if (n >= 400) fail_now("msg_handshake");
                @(posedge clk); #1;
            end
        end
        bus.mold_msg_v_i     = 1'b0;
        bus.mold_msg_start_i = 1'b0;
    endtask

    task automatic sink(input bit stall);
        int cyc = 0;
        int stall_left = 0;
        bit d1 = 0, dl = 0, holding = 0, done = 0;
        logic [72:0] held, cur;
        held = '0;
        msg_rdy_seen = 0;
        cap_data.delete(); cap_keep.delete(); cap_last.delete();
        while (!done && cyc < 600) begin
            @(posedge clk); #1;
            if (stall && bus.upd_axis_tvalid_o && stall_left == 0) begin
                if (cap_data.size() == 1 && !d1) begin d1 = 1; stall_left = 3; end
                else if (bus.upd_axis_tlast_o && !dl) begin dl = 1; stall_left = 3; end
            end
            if (stall_left > 0) begin bus.upd_axis_tready_i = 1'b0; stall_left--; end
            else bus.upd_axis_tready_i = 1'b1;
            @(negedge clk);
            cyc++;
            if (bus.mold_msg_ready_o) msg_rdy_seen = 1;
            cur = {bus.upd_axis_tdata_o, bus.upd_axis_tkeep_o, bus.upd_axis_tlast_o};
            if (holding) check("stall_hold", {bus.upd_axis_tvalid_o, cur}, {1'b1, held});
            if (bus.upd_axis_tvalid_o) begin
                if (bus.upd_axis_tready_i) begin
                    cap_data.push_back(bus.upd_axis_tdata_o);
                    cap_keep.push_back(bus.upd_axis_tkeep_o);
                    cap_last.push_back(bus.upd_axis_tlast_o);
                    holding = 0;
                    if (bus.upd_axis_tlast_o) done = 1;
                end else begin
                    holding = 1;
                    held    = cur;
                end
            end
        end
        if (!done) fail_now("sink_tlast");
    endtask

    task automatic abort_mid_msg();
        @(posedge clk); #1;
        bus.pkt_v_i = 1'b1; bus.pkt_sid_i = 80'h77; bus.pkt_msg_cnt_i = 16'd2;
        @(posedge clk); #1;
        bus.pkt_v_i          = 1'b0;
        bus.mold_msg_v_i     = 1'b1;
        bus.mold_msg_start_i = 1'b1;
        bus.mold_msg_len_i   = 16'd40;
        bus.mold_msg_mask_i  = 8'hFF;
        bus.mold_msg_data_i  = 64'h1122_3344_5566_7788;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("abort_in_msg", 128'(bus.upd_axis_tvalid_o), 128'(1));
        nreset = 1'b0;
        #1;
        check("abort_outs", {bus.upd_axis_tvalid_o, bus.upd_axis_tkeep_o, bus.upd_axis_tdata_o,
                             bus.upd_axis_tlast_o, bus.pkt_ready_o, bus.mold_msg_ready_o}, '0);
        check("abort_seq", 128'(dut.seq_q), 128'(0));
        @(posedge clk); #1;
        bus.mold_msg_v_i     = 1'b0;
        bus.mold_msg_start_i = 1'b0;
        @(posedge clk); #1;
        nreset  = 1'b1;
        exp_seq = 64'h0;
    endtask

    initial begin
        int nb;
        logic [63:0] ed, am;
        logic [7:0]  ek;
        tbl[0] = '{80'hDEADBEEF, 16'd1, 16, 0, 0, 0, 1, 0, 0, 0, 5, 8'h3F, 64'hF0F0F0F0F0F0F0F1};
        tbl[1] = '{80'h0123456789ABCDEF1122, 16'd0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 8'h0F, 64'hF0F0F0F0F0F0F0F1};
        tbl[2] = '{80'h55, 16'd2, 3, 5, 0, 0, 0, 0, 0, 0, 4, 8'hFF, 64'hF0F0F0F0F0F0F0F3};
        tbl[3] = '{80'hDEADBEEF, 16'd1, 16, 0, 0, 0, 1, 1, 0, 0, 5, 8'h3F, 64'hF0F0F0F0F0F0F0F4};
        tbl[4] = '{80'h9999, 16'd4, 1, 2, 9, 8, 0, 0, 1, 0, 6, 8'hFF, 64'h100};
        tbl[5] = '{80'h4242, 16'd1, 7, 0, 0, 0, 0, 0, 0, 0, 4, 8'h1F, 64'h101};
        tbl[6] = '{80'hA5, 16'd1, 10, 0, 0, 0, 0, 0, 0, 1, 4, 8'hFF, 64'h1};
        tbl[7] = '{80'hC0FFEE, 16'd3, 20, 1, 13, 0, 0, 1, 0, 0, 8, 8'h0F, 64'h4};

        nreset = 1'b0;
        bus.seq_load_i = 1'b0; bus.seq_i = '0; bus.pkt_v_i = 1'b0; bus.pkt_sid_i = '0;
        bus.pkt_msg_cnt_i = '0; bus.mold_msg_v_i = 1'b0; bus.mold_msg_start_i = 1'b0;
        bus.mold_msg_len_i = '0; bus.mold_msg_mask_i = '0; bus.mold_msg_data_i = '0;
        bus.upd_axis_tready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {bus.upd_axis_tvalid_o, bus.upd_axis_tkeep_o, bus.upd_axis_tdata_o,
                             bus.upd_axis_tlast_o, bus.upd_axis_tuser_o, bus.pkt_ready_o,
                             bus.mold_msg_ready_o}, '0);
        check("reset_seq", 128'(dut.seq_q), 128'(0));
        nreset = 1'b1;
        @(posedge clk); #1;
        bus.seq_load_i = 1'b1;
        bus.seq_i      = 64'hF0F0F0F0F0F0F0F0;
        @(posedge clk); #1;
        bus.seq_load_i = 1'b0;
        check("seq_load_idle", 128'(dut.seq_q), 128'(64'hF0F0F0F0F0F0F0F0));
        exp_seq = 64'hF0F0F0F0F0F0F0F0;

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].pre_rst) abort_mid_msg();
            build_exp(tbl[i], exp_seq);
            exp_seq = tbl[i].load ? 64'h100 : exp_seq + 64'(tbl[i].cnt);
            fork
                drive(tbl[i]);
                sink(tbl[i].stall);
            join
            @(negedge clk);
            check($sformatf("v%0d_ready_after_last", i), 128'(bus.pkt_ready_o), 128'(1));
            check($sformatf("v%0d_beats", i), 128'(cap_data.size()), 128'(tbl[i].exp_beats));
            if (cap_keep.size() > 0)
                check($sformatf("v%0d_last_keep", i), 128'(cap_keep[cap_keep.size()-1]), 128'(tbl[i].exp_keep));
            check($sformatf("v%0d_seq", i), 128'(dut.seq_q), 128'(tbl[i].exp_seq));
            if (tbl[i].cnt == 16'd0)
                check($sformatf("v%0d_hb_no_msg_ready", i), 128'(msg_rdy_seen), 128'(0));
            nb = (exp_bytes.size() + 7) / 8;
            for (int b = 0; b < cap_data.size() && b < nb; b++) begin
                ed = '0; ek = '0; am = '0;
                for (int j = 0; j < 8; j++)
                    if (8 * b + j < exp_bytes.size()) begin
                        ed[8*j +: 8] = exp_bytes[8*b+j];
                        ek[j]        = 1'b1;
                        am[8*j +: 8] = 8'hFF;
                    end
                check($sformatf("v%0d_beat%0d", i, b),
                      {cap_data[b] & am, cap_keep[b], cap_last[b]}, {ed, ek, (b == nb - 1)});
            end
            if ((i == 0 || i == 3) && cap_data.size() > 2)
                check($sformatf("v%0d_beat2_const", i), 128'(cap_data[2]), 128'(64'hFFFF_0010_0001_F0F0));
            if (i == 2 && cap_data.size() > 3) begin
                check("v2_prefix1_lanes45", 128'(cap_data[2][47:32]), 128'(16'h0003));
                check("v2_prefix2_bytes25_26", 128'(cap_data[3][23:8]), 128'(16'h0005));
            end
            if (i == 4 && cap_data.size() > 1)
                check("v4_hdr_old_seq", 128'(cap_data[1][63:16]), 128'(48'hF0F0F0F0F0F4));
            if (i == 5 && cap_data.size() > 1)
                check("v5_hdr_loaded_seq", 128'(cap_data[1][63:16]), 128'(48'h000000000100));
            if (i == 6 && cap_data.size() > 1)
                check("v6_hdr_seq_zero", 128'(cap_data[1][63:16]), 128'(48'h0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
